// File: rtl/dmem_port_arbiter_pkg.sv
// dmem_port_arbiter_pkg: shared state encoding and access codes for the data-memory port arbiter.
package dmem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CPU_ACC  = 2'd1,
      HOST_ACC = 2'd2
   } arb_state_t;

   localparam logic [2:0] RW_WORD = 3'b010;

   // Host writes into the MMIO window never reach memory.
   function automatic logic host_blocked(input logic we, input logic [31:0] addr, input logic [31:0] base);
      return we && (addr >= base);
   endfunction

endpackage

// File: rtl/dmem_lat_counter.sv
// dmem_lat_counter: access-phase counter; zero marks the strobe cycle, done marks the completion cycle.
module dmem_lat_counter #(
   parameter int MEM_LAT = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic zero,
   output logic done
);

   localparam int W = $clog2(MEM_LAT + 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      cnt <= (rst || clr) ? '0 : inc ? cnt + 1'b1 : cnt;
   end

   assign zero = cnt == '0;
   assign done = cnt == W'(MEM_LAT);

endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: serialises CPU and host accesses onto one data-memory port with fixed read latency.
module dmem_port_arbiter
   import dmem_port_arbiter_pkg::*;
#(
   parameter int          MEM_LAT   = 1,
   parameter bit          CPU_PRIO  = 1'b1,
   parameter logic [31:0] MMIO_BASE = 32'h0000_03F0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic [2:0]  cpu_rw_type,
   output logic        cpu_ack,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   input  logic        host_req,
   input  logic        host_we,
   input  logic [31:0] host_addr,
   input  logic [31:0] host_wdata,
   output logic        host_ack,
   output logic [31:0] host_rdata,
   output logic        host_err,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [2:0]  mem_rw_type,
   input  logic [31:0] mem_rdata
);

   arb_state_t state;
   logic       last_grant;
   logic       cnt_zero;
   logic       cnt_done;
   logic       cpu_sel;
   logic       host_sel;
   logic       acc;
   logic       other_req;
   logic       pick_cpu;
   logic       blk;
   logic       go;

   assign cpu_sel   = state == CPU_ACC;
   assign host_sel  = state == HOST_ACC;
   assign acc       = cpu_sel || host_sel;
   assign other_req = cpu_sel ? host_req : cpu_req;
   assign blk       = host_blocked(host_we, host_addr, MMIO_BASE);
   assign pick_cpu  = cpu_req && (!host_req || CPU_PRIO || last_grant);

   dmem_lat_counter #(
      .MEM_LAT(MEM_LAT)
   ) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (!acc || cnt_done),
      .inc (acc),
      .zero(cnt_zero),
      .done(cnt_done)
   );

   // Ack cycle hands the port straight to a waiting requester, giving strict alternation.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
      end else if (!acc) begin
         if (pick_cpu) begin
            state      <= CPU_ACC;
            last_grant <= 1'b0;
         end else if (host_req) begin
            state      <= HOST_ACC;
            last_grant <= 1'b1;
         end else begin
            state      <= IDLE;
         end
      end else if (cnt_done) begin
         state <= other_req ? (cpu_sel ? HOST_ACC : CPU_ACC) : IDLE;
         if (other_req) last_grant <= cpu_sel;
      end
   end

   // Everything is gated by rst so an abandoned access can never complete.
   assign go          = !rst && cnt_zero && (cpu_sel || (host_sel && !blk));
   assign mem_en      = go;
   assign mem_we      = go && (cpu_sel ? cpu_we : host_we);
   assign mem_addr    = !go ? '0 : cpu_sel ? cpu_addr : host_addr;
   assign mem_wdata   = !go ? '0 : cpu_sel ? cpu_wdata : host_wdata;
   assign mem_rw_type = !go ? '0 : cpu_sel ? cpu_rw_type : RW_WORD;

   assign cpu_ack    = !rst && cpu_sel && cnt_done;
   assign host_ack   = !rst && host_sel && cnt_done;
   assign cpu_rdata  = (cpu_ack && !cpu_we) ? mem_rdata : '0;
   assign host_rdata = (host_ack && !host_we) ? mem_rdata : '0;
   assign host_err   = host_ack && blk;
   assign cpu_stall  = !rst && cpu_req && !cpu_ack;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: scoreboard bench for two arbiter configurations (latency 1 / CPU priority, latency 3 / round-robin).
module tb_dmem_port_arbiter;

   localparam logic [31:0] MMIO = 32'h0000_03F0;

   typedef struct {
      int          dly;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  rw;
   } txn_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [2:0]  rw;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_pass  = 0;
   int n_total = 0;
   bit h_done[2];

   task automatic chk(input int h, input string nm, input logic [31:0] act, input logic [31:0] want);
      n_total++;
      if (act === want) n_pass++;
      else $display("FAIL h%0d %s: got %h expected %h", h, nm, act, want);
   endtask

   function automatic logic [31:0] init_word(input logic [7:0] i);
      return (i == 8'd4) ? 32'hDEADBEEF : {16'hC0DE, 8'h00, i};
   endfunction

   function automatic txn_t mk(input int dly, input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] rw);
      txn_t t;
      t.dly = dly; t.we = we; t.addr = addr; t.wdata = wdata; t.rw = rw;
      return t;
   endfunction

   function automatic logic [31:0] rnd_cpu_addr();
      return 32'($urandom_range(0, 63)) << 2;
   endfunction

   function automatic logic [31:0] rnd_host_addr();
      return ($urandom_range(0, 3) == 0) ? (MMIO | (32'($urandom_range(0, 3)) << 2))
                                         : (32'h100 | (32'($urandom_range(0, 63)) << 2));
   endfunction

   for (genvar g = 0; g < 2; g++) begin : h
      localparam int LAT  = (g == 0) ? 1 : 3;
      localparam bit PRIO = (g == 0);

      logic        rst;
      logic        req[2];
      logic        we[2];
      logic [31:0] addr[2];
      logic [31:0] wdata[2];
      logic [2:0]  cpu_rw;
      logic        ack[2];
      logic [31:0] rdata[2];
      logic        cpu_stall, host_err;
      logic        mem_en, mem_we;
      logic [31:0] mem_addr, mem_wdata, mem_rdata;
      logic [2:0]  mem_rw_type;

      dmem_port_arbiter #(
         .MEM_LAT (LAT),
         .CPU_PRIO(PRIO)
      ) dut (
         .clk        (clk),
         .rst        (rst),
         .cpu_req    (req[0]),
         .cpu_we     (we[0]),
         .cpu_addr   (addr[0]),
         .cpu_wdata  (wdata[0]),
         .cpu_rw_type(cpu_rw),
         .cpu_ack    (ack[0]),
         .cpu_rdata  (rdata[0]),
         .cpu_stall  (cpu_stall),
         .host_req   (req[1]),
         .host_we    (we[1]),
         .host_addr  (addr[1]),
         .host_wdata (wdata[1]),
         .host_ack   (ack[1]),
         .host_rdata (rdata[1]),
         .host_err   (host_err),
         .mem_en     (mem_en),
         .mem_we     (mem_we),
         .mem_addr   (mem_addr),
         .mem_wdata  (mem_wdata),
         .mem_rw_type(mem_rw_type),
         .mem_rdata  (mem_rdata)
      );

      // Memory with LAT-cycle read pipe; junk data outside read slots exposes mistimed sampling.
      bit          wr_valid[256];
      logic [31:0] wr_data[256];
      logic [31:0] pipe[LAT];
      logic [31:0] mem_read;
      assign mem_read  = wr_valid[mem_addr[9:2]] ? wr_data[mem_addr[9:2]] : init_word(mem_addr[9:2]);
      assign mem_rdata = pipe[LAT-1];
      always @(posedge clk) begin
         if (mem_en && mem_we) begin
            wr_valid[mem_addr[9:2]] <= 1'b1;
            wr_data[mem_addr[9:2]]  <= mem_wdata;
         end
         pipe[0] <= (mem_en && !mem_we) ? mem_read : 32'hBAD0_BAD0;
         for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end

      txn_t        tx_q[2][$];
      exp_t        exp_q[2][$];
      logic [31:0] ref_m[logic [31:0]];
      bit          busy[2];
      int          issue_cyc[2];

      for (genvar r = 0; r < 2; r++) begin : d
         initial begin
            txn_t t;
            exp_t e;
            int   n;
            req[r] = 1'b0; we[r] = 1'b0; addr[r] = '0; wdata[r] = '0;
            if (r == 0) cpu_rw = '0;
            forever begin
               @(posedge clk); #1;
               if (tx_q[r].size() == 0) begin
                  req[r]  = 1'b0;
                  busy[r] = 1'b0;
               end else begin
                  busy[r] = 1'b1;
                  t = tx_q[r].pop_front();
                  if (t.dly > 0) begin
                     req[r] = 1'b0;
                     repeat (t.dly) begin @(posedge clk); #1; end
                  end
                  e.we    = t.we;
                  e.addr  = t.addr;
                  e.wdata = t.wdata;
                  e.rw    = (r == 0) ? t.rw : 3'b010;
                  e.err   = (r == 1) && t.we && (t.addr >= MMIO);
                  e.rdata = t.we ? 32'h0 : ref_m.exists(t.addr) ? ref_m[t.addr] : init_word(t.addr[9:2]);
                  if (t.we && !e.err) ref_m[t.addr] = t.wdata;
                  exp_q[r].push_back(e);
                  we[r] = t.we; addr[r] = t.addr; wdata[r] = t.wdata;
                  if (r == 0) cpu_rw = t.rw;
                  req[r] = 1'b1;
                  issue_cyc[r] = cyc;
                  n = 0;
                  do begin @(negedge clk); n++; end while (!ack[r] && !rst && n < 400);
                  if (rst) exp_q[r].delete();
                  else if (!ack[r]) begin
                     chk(g, r ? "host ack timeout" : "cpu ack timeout", 32'(ack[r]), 32'd1);
                     exp_q[r].delete();
                  end
               end
            end
         end
      end

      int          en_cnt = 0, en_cyc = 0, last_acked = 1;
      int          n_ack[2];
      int          ack_log[$], ack_cyc_log[$];
      logic        cap_we;
      logic [31:0] cap_addr, cap_wdata;
      logic [2:0]  cap_rw;
      exp_t        me;

      always @(negedge clk) begin
         if (rst) en_cnt = 0;
         else begin
            chk(g, "cpu_stall", 32'(cpu_stall), 32'(req[0] && !ack[0]));
            chk(g, "host_err without ack", 32'(host_err && !ack[1]), 32'd0);
            if (mem_en) begin
               en_cnt++; en_cyc = cyc;
               cap_we = mem_we; cap_addr = mem_addr; cap_wdata = mem_wdata; cap_rw = mem_rw_type;
            end
            for (int k = 0; k < 2; k++) if (ack[k]) begin
               if (exp_q[k].size() == 0) chk(g, k ? "unexpected host_ack" : "unexpected cpu_ack", 32'd1, 32'd0);
               else begin
                  me = exp_q[k].pop_front();
                  chk(g, k ? "host_rdata" : "cpu_rdata", rdata[k], me.rdata);
                  if (k == 1) chk(g, "host_err", 32'(host_err), 32'(me.err));
                  chk(g, "mem_en count per access", en_cnt, me.err ? 0 : 1);
                  if (!me.err && en_cnt == 1) begin
                     chk(g, "mem_en to ack latency", cyc - en_cyc, LAT);
                     chk(g, "mem_addr", cap_addr, me.addr);
                     chk(g, "mem_we", 32'(cap_we), 32'(me.we));
                     chk(g, "mem_rw_type", 32'(cap_rw), 32'(me.rw));
                     if (me.we) chk(g, "mem_wdata", cap_wdata, me.wdata);
                  end
               end
               ack_log.push_back(k);
               ack_cyc_log.push_back(cyc);
               last_acked = k;
               n_ack[k]++;
               en_cnt = 0;
            end
         end
      end

      task automatic wait_idle(input int budget);
         int n = 0;
         while ((tx_q[0].size() + tx_q[1].size() + exp_q[0].size() + exp_q[1].size() != 0
                 || busy[0] || busy[1]) && n < budget) begin
            @(negedge clk); n++;
         end
         if (n >= budget) chk(g, "idle timeout", 32'(n), 32'(budget - 1));
         repeat (2) @(negedge clk);
      endtask

      function automatic logic any_out();
         return |{ack[0], ack[1], rdata[0], rdata[1], cpu_stall, host_err,
                  mem_en, mem_we, mem_addr, mem_wdata, mem_rw_type};
      endfunction

      initial begin
         int want, acks_before;
         rst = 1'b1;
         repeat (3) @(posedge clk);
         @(negedge clk);
         chk(g, "outputs in reset", 32'(any_out()), 32'd0);
         @(posedge clk); #1 rst = 1'b0;

         tx_q[0].push_back(mk(0, 1'b0, 32'h10, 32'h0, 3'b010));
         wait_idle(50);
         chk(g, "single cpu read latency", ack_cyc_log[$] - issue_cyc[0], 1 + LAT);

         want = PRIO ? 0 : 1 - last_acked;
         ack_log.delete(); ack_cyc_log.delete();
         tx_q[0].push_back(mk(0, 1'b0, 32'h20, 32'h0, 3'b100));
         tx_q[1].push_back(mk(0, 1'b0, 32'h140, 32'h0, 3'b0));
         wait_idle(80);
         chk(g, "simultaneous first grant", ack_log[0], want);
         chk(g, "simultaneous second grant", ack_log[1], 1 - want);
         chk(g, "back-to-back ack spacing", ack_cyc_log[1] - ack_cyc_log[0], 1 + LAT);

         want = PRIO ? 0 : 1 - last_acked;
         ack_log.delete(); ack_cyc_log.delete();
         for (int i = 0; i < 3; i++) begin
            tx_q[0].push_back(mk(0, 1'($urandom), rnd_cpu_addr(), $urandom, 3'($urandom)));
            tx_q[1].push_back(mk(0, 1'($urandom), 32'h100 | (32'(i) << 4), $urandom, 3'b0));
         end
         wait_idle(200);
         for (int i = 0; i < 6; i++) chk(g, "contention grant order", ack_log[i], want ^ (i & 1));
         for (int i = 1; i < 6; i++) chk(g, "contention ack spacing", ack_cyc_log[i] - ack_cyc_log[i-1], 1 + LAT);

         tx_q[1].push_back(mk(0, 1'b1, 32'h3F4, 32'h1234_5678, 3'b0));
         tx_q[1].push_back(mk(1, 1'b1, 32'h100, 32'hCAFE_F00D, 3'b0));
         tx_q[1].push_back(mk(0, 1'b0, 32'h3F4, 32'h0, 3'b0));
         tx_q[1].push_back(mk(2, 1'b0, 32'h100, 32'h0, 3'b0));
         tx_q[0].push_back(mk(3, 1'b1, 32'h30, 32'h0BAD_CAFE, 3'b001));
         tx_q[0].push_back(mk(0, 1'b0, 32'h30, 32'h0, 3'b101));
         wait_idle(200);

         for (int i = 0; i < 30; i++) begin
            tx_q[0].push_back(mk($urandom_range(0, 3), 1'($urandom), rnd_cpu_addr(), $urandom, 3'($urandom)));
            tx_q[1].push_back(mk($urandom_range(0, 3), 1'($urandom), rnd_host_addr(), $urandom, 3'b0));
         end
         wait_idle(3000);

         tx_q[1].push_back(mk(0, 1'b0, 32'h104, 32'h0, 3'b0));
         want = 0;
         while (!mem_en && want < 50) begin @(negedge clk); want++; end
         chk(g, "abort read reached memory", 32'(mem_en), 32'd1);
         acks_before = n_ack[1];
         @(posedge clk); #1 rst = 1'b1;
         @(posedge clk); #1 rst = 1'b0;
         @(negedge clk);
         chk(g, "outputs after mid-access reset", 32'(any_out()), 32'd0);
         repeat (8) @(negedge clk);
         chk(g, "no host_ack for abandoned read", n_ack[1] - acks_before, 0);
         tx_q[1].push_back(mk(0, 1'b0, 32'h104, 32'h0, 3'b0));
         wait_idle(50);
         chk(g, "reissued host read latency", ack_cyc_log[$] - issue_cyc[1], 1 + LAT);
         h_done[g] = 1'b1;
      end
   end

   initial begin
      while (!(h_done[0] && h_done[1]) && cyc < 60000) @(negedge clk);
      if (!(h_done[0] && h_done[1])) begin
         n_total++;
         $display("FAIL global timeout: cycle %0d reached without both configurations finishing", cyc);
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
